ex_muldiv_seq: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide operations in the EX stage. It accepts one operation at a time from the ID/EX register using already-forwarded operands. It runs an iterative shift-add multiply or restoring divide, and holds a stall request to the hazard logic until the result is ready. On completion it presents the result for one cycle so the EX/MEM register can capture it in place of the ALU output.

---
 rtl/ex_muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Stalls the front of the pipeline while an operation runs and pulses done with the result.
module ex_muldiv_seq #(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [REG_WIDTH-1:0] src_a,
    input  logic [REG_WIDTH-1:0] src_b,
    input  logic                 flush,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [REG_WIDTH-1:0] result
);

    localparam int unsigned W  = REG_WIDTH;
    localparam int unsigned CW = $clog2(REG_WIDTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W-1:0]    opb_q, opb_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    result_q, result_d;

    // Operand decode for a new request
    op_t             op_in;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic            div_by_zero, div_ovf;

    assign op_in    = op_t'(op);
    assign a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign a_neg    = a_signed & src_a[W-1];
    assign b_neg    = b_signed & src_b[W-1];
    assign a_mag    = a_neg ? ('0 - src_a) : src_a;
    assign b_mag    = b_neg ? ('0 - src_b) : src_b;
    assign div_by_zero = op_in[2] & (src_b == '0);
    assign div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                         (src_a == MOST_NEG) && (src_b == '1);

    // Shift-add multiply step: prod_q = {partial high, remaining multiplier bits}
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;

    assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, prod_q[W-1:1]};

    // Restoring divide step: prod_q = {remainder, quotient/dividend}
    logic [W:0]      rem_sh, rem_diff;
    logic            div_ge;
    logic [2*W-1:0]  div_next;

    assign rem_sh   = {prod_q[2*W-1:W], prod_q[W-1]};
    assign rem_diff = rem_sh - {1'b0, opb_q};
    assign div_ge   = ~rem_diff[W];
    assign div_next = div_ge ? {rem_diff[W-1:0], prod_q[W-2:0], 1'b1}
                             : {rem_sh[W-1:0],   prod_q[W-2:0], 1'b0};

    // Sign correction applied in FIX
    logic [2*W-1:0]  mul_full;
    logic [W-1:0]    div_sel, div_fix, fix_val;

    assign mul_full = neg_q ? ('0 - prod_q) : prod_q;
    assign div_sel  = op_q[1] ? prod_q[2*W-1:W] : prod_q[W-1:0];
    assign div_fix  = neg_q ? ('0 - div_sel) : div_sel;
    assign fix_val  = op_q[2]           ? div_fix :
                      (op_q == OP_MUL)  ? mul_full[W-1:0] : mul_full[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        prod_d   = prod_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        stall    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                stall = start & ~flush;
                if (start && !flush) begin
                    op_d    = op_in;
                    neg_d   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
                    count_d = CW'(REG_WIDTH - 1);
                    if (op_in[2]) begin
                        prod_d = {{W{1'b0}}, a_mag};
                        opb_d  = b_mag;
                    end else begin
                        prod_d = {{W{1'b0}}, b_mag};
                        opb_d  = a_mag;
                    end
                    state_d = S_RUN;
                    if (div_by_zero) begin
                        result_d = op_in[1] ? src_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op_in[1] ? '0 : src_a;
                        state_d  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                stall   = 1'b1;
                prod_d  = op_q[2] ? div_next : mul_next;
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                stall    = 1'b1;
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect squashes whatever is in flight without touching result
        if (flush && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            prod_q   <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: directed cases plus random ops against an arithmetic model.
module tb_ex_muldiv_seq;

    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        stall, busy, done;
    logic [31:0] result;

    ex_muldiv_seq #(.REG_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return o[2] && (b == 0 || (!o[0] && a == MIN && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h with no op outstanding", result);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] expv, output int unsigned n);
        int unsigned guard = 0;
        exp_t e;
        while (busy && guard < 200) begin
            step();
            guard++;
        end
        check("launch_wait_idle", busy, 1'b0);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        n     = cyc;
        if (push) begin
            e.res = expv;
            e.cyc = n + (is_special(o, a, b) ? 1 : 34);
            exp_q.push_back(e);
        end
        #1;
        check("stall_on_start", stall, 1'b1);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 200) begin
            step();
            guard++;
        end
        check("wait_idle_timeout", (busy || exp_q.size() != 0), 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n, n2, bad, d0;
        logic [31:0] prev, a, b;
        logic [2:0]  o;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        src_a = '0;
        src_b = '0;
        repeat (3) step();
        check("reset_result", result, 32'h0);
        check("reset_done",   done,   1'b0);
        check("reset_busy",   busy,   1'b0);
        check("reset_stall",  stall,  1'b0);
        reset = 1'b0;
        step();

        // MUL with stall profile
        launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, n);
        bad = 0;
        while (cyc < n + 34) begin
            if (!stall) bad++;
            step();
        end
        check("stall_during_op", bad, 0);
        check("stall_low_in_done", stall, 1'b0);
        check("busy_in_done", busy, 1'b1);
        wait_idle();

        launch(3'd1, MIN, 32'hFFFF_FFFF, 1, 32'h0000_0000, n);
        launch(3'd3, MIN, 32'hFFFF_FFFF, 1, 32'h7FFF_FFFF, n);
        launch(3'd2, MIN, 32'hFFFF_FFFF, 1, 32'h8000_0000, n);
        launch(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, n);
        launch(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, n);
        launch(3'd5, 32'd100, 32'd7, 1, 32'd14, n);
        launch(3'd7, 32'd100, 32'd7, 1, 32'd2, n);
        launch(3'd4, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, n);
        launch(3'd7, 32'd5, 32'd0, 1, 32'd5, n);
        launch(3'd4, MIN, 32'hFFFF_FFFF, 1, 32'h8000_0000, n);
        launch(3'd6, MIN, 32'hFFFF_FFFF, 1, 32'h0, n);
        wait_idle();

        // Back-to-back: second start in the IDLE cycle right after done
        launch(3'd0, 32'd1234, 32'd5678, 1, 32'd7006652, n);
        launch(3'd5, 32'd1000, 32'd9, 1, 32'd111, n2);
        check("back_to_back_gap", n2, n + 35);
        wait_idle();

        // Flush mid-RUN
        prev = result;
        d0   = done_cnt;
        launch(3'd5, 32'd5000, 32'd3, 0, 32'h0, n);
        while (cyc < n + 10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_busy",   busy,   1'b0);
        check("flush_stall",  stall,  1'b0);
        check("flush_result", result, prev);
        repeat (40) step();
        check("flush_no_done", done_cnt, d0);

        // start together with flush in IDLE
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("start_flush_stall", stall, 1'b0);
        step();
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_busy", busy, 1'b0);
        check("start_flush_result", result, prev);

        // Reset in the middle of a DIVU
        launch(3'd0, 32'd9, 32'd9, 1, 32'd81, n);
        wait_idle();
        launch(3'd5, 32'd777, 32'd5, 0, 32'h0, n);
        while (cyc < n + 5) step();
        reset = 1'b1;
        step();
        check("midreset_result", result, 32'h0);
        check("midreset_busy",   busy,   1'b0);
        check("midreset_stall",  stall,  1'b0);
        check("midreset_done",   done,   1'b0);
        reset = 1'b0;
        step();

        // start held high for the whole operation
        d0 = done_cnt;
        begin
            exp_t e;
            start = 1'b1;
            op    = 3'd0;
            src_a = 32'd300;
            src_b = 32'd301;
            n     = cyc;
            e.res = 32'd90300;
            e.cyc = n + 34;
            exp_q.push_back(e);
        end
        step();
        bad = 0;
        while (cyc < n + 34) begin
            if (!busy) bad++;
            step();
        end
        start = 1'b0;
        check("held_start_busy", bad, 0);
        wait_idle();
        check("held_start_single_done", done_cnt, d0 + 1);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            launch(o, a, b, 1, ref_model(o, a, b), n);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
